// File: rtl/gcd_controller.sv
// ---------------------------------------------------------------------------
// gcd_controller
//   Control FSM for a subtract-based GCD datapath (IDLE -> LOAD -> COMPUTE ->
//   DONE). The datapath holds X, Y and a result register and reports two
//   comparator flags. This block drives that datapath's mux selects and load
//   enables.
//
//   Optional feature: define GCD_CTRL_TIMEOUT_EN to add an iteration counter
//   and a timeout output. With the feature enabled, an operation that runs
//   MAX_ITER subtraction cycles without the operands becoming equal is
//   forced to DONE. The default build omits both the counter and the port.
//
// Parameters
//   MAX_ITER  - subtraction-cycle limit per operation (timeout build only)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   go        in   start request, sampled only in IDLE
//   x_lt_y    in   datapath flag: X < Y
//   x_ne_y    in   datapath flag: X != Y
//   x_sel     out  X mux select (0 = operand, 1 = X-Y)
//   x_en      out  X register load enable
//   y_sel     out  Y mux select (0 = operand, 1 = Y-X)
//   y_en      out  Y register load enable
//   output_en out  result register load enable
//   busy      out  high whenever the FSM is not in IDLE
//   done      out  one-cycle pulse; the result register is valid
//   timeout   out  high with done when MAX_ITER ran out (timeout build only)
// ---------------------------------------------------------------------------
module gcd_controller #(
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic x_lt_y,
    input  logic x_ne_y,
    output logic x_sel,
    output logic x_en,
    output logic y_sel,
    output logic y_en,
    output logic output_en,
    output logic busy,
    output logic done
`ifdef GCD_CTRL_TIMEOUT_EN
    ,
    output logic timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;

    // High in a COMPUTE cycle in which the iteration budget is exhausted.
    logic iter_limit;

    if (MAX_ITER < 1) begin : g_bad_max_iter
        $error("gcd_controller: MAX_ITER must be at least 1");
    end

`ifdef GCD_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);
    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] iter_cnt;

    assign iter_limit = (state == COMPUTE) && (iter_cnt == ITER_LIMIT);

    // Counts only the cycles that actually load a difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (state == LOAD) begin
            iter_cnt <= '0;
        end else if (state == COMPUTE && x_ne_y && !iter_limit) begin
            iter_cnt <= iter_cnt + CNT_W'(1);
        end
    end
`else
    assign iter_limit = 1'b0;
`endif

    // State register plus the state-derived status outputs. busy/done/timeout
    // are registered alongside the transition so they are clean flop outputs
    // that track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef GCD_CTRL_TIMEOUT_EN
            timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    if (!x_ne_y) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (iter_limit) begin
                        state   <= DONE;
                        done    <= 1'b1;
`ifdef GCD_CTRL_TIMEOUT_EN
                        timeout <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
`ifdef GCD_CTRL_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath controls decode from state and flags in the same cycle, so a
    // subtraction result is loaded on the edge right after the flags settle.
    always_comb begin
        x_sel     = 1'b0;
        x_en      = 1'b0;
        y_sel     = 1'b0;
        y_en      = 1'b0;
        output_en = 1'b0;
        case (state)
            LOAD: begin
                x_en = 1'b1;
                y_en = 1'b1;
            end
            COMPUTE: begin
                if (!x_ne_y) begin
                    output_en = 1'b1;
                end else if (!iter_limit) begin
                    if (x_lt_y) begin
                        y_en  = 1'b1;
                        y_sel = 1'b1;
                    end else begin
                        x_en  = 1'b1;
                        x_sel = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// ---------------------------------------------------------------------------
// tb_gcd_controller
//   Directed bench for gcd_controller. A behavioural 8-bit GCD datapath
//   (X, Y, result registers and comparator flags) is wrapped around the
//   controller. Each started operation pushes its expected result, latency,
//   subtraction count and timeout flag onto a scoreboard; the done monitor
//   pops and compares. Build with GCD_CTRL_TIMEOUT_EN to add the timeout case.
// ---------------------------------------------------------------------------
module tb_gcd_controller;

    localparam int unsigned TB_MAX_ITER = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic x_lt_y, x_ne_y;
    logic x_sel, x_en, y_sel, y_en, output_en, busy, done;
`ifdef GCD_CTRL_TIMEOUT_EN
    logic timeout_o;
`else
    logic timeout_o = 1'b0;
`endif

    logic [7:0] a_in = 8'd0;
    logic [7:0] b_in = 8'd0;
    logic [7:0] xr   = 8'd0;
    logic [7:0] yr   = 8'd0;
    logic [7:0] rr   = 8'd0;

    typedef struct {
        logic [7:0]  res;
        int unsigned lat;
        int unsigned subs;
        logic        to;
    } exp_t;

    exp_t sb_q[$];

    int unsigned total     = 0;
    int unsigned bad       = 0;
    int unsigned done_cnt  = 0;
    int unsigned cyc       = 0;
    int unsigned start_cyc = 0;
    int unsigned sub_cnt   = 0;
    int unsigned oe_cnt    = 0;

    always #5 clk = ~clk;

`ifdef GCD_CTRL_TIMEOUT_EN
    gcd_controller #(.MAX_ITER(TB_MAX_ITER)) dut (
        .clk(clk), .rst(rst), .go(go), .x_lt_y(x_lt_y), .x_ne_y(x_ne_y),
        .x_sel(x_sel), .x_en(x_en), .y_sel(y_sel), .y_en(y_en),
        .output_en(output_en), .busy(busy), .done(done), .timeout(timeout_o)
    );
`else
    gcd_controller dut (
        .clk(clk), .rst(rst), .go(go), .x_lt_y(x_lt_y), .x_ne_y(x_ne_y),
        .x_sel(x_sel), .x_en(x_en), .y_sel(y_sel), .y_en(y_en),
        .output_en(output_en), .busy(busy), .done(done)
    );
`endif

    // Behavioural datapath
    always @(posedge clk) begin
        if (x_en) xr <= x_sel ? xr - yr : a_in;
        if (y_en) yr <= y_sel ? yr - xr : b_in;
        if (output_en) rr <= xr;
    end
    assign x_lt_y = (xr < yr);
    assign x_ne_y = (xr != yr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t ref_op(input logic [7:0] a_i, input logic [7:0] b_i);
        exp_t e;
        logic [7:0] a;
        logic [7:0] b;
        a = a_i;
        b = b_i;
        e.subs = 0;
        e.to   = 1'b0;
        while (a != b && e.subs < 1000) begin
`ifdef GCD_CTRL_TIMEOUT_EN
            if (e.subs == TB_MAX_ITER) begin
                e.to = 1'b1;
                break;
            end
`endif
            if (a < b) b = b - a;
            else       a = a - b;
            e.subs++;
        end
        e.res = a;
        e.lat = e.subs + 3;
        return e;
    endfunction

    // Cycle counter and go-sampling edge capture
    always @(posedge clk) begin
        cyc++;
        if (!rst && go && !busy) begin
            start_cyc = cyc;
            sub_cnt   = 0;
            oe_cnt    = 0;
        end
    end

    // Per-cycle invariants and scoreboard comparison on done
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            chk("x_sel_gated", x_en || !x_sel, 1);
            chk("y_sel_gated", y_en || !y_sel, 1);
            chk("dual_en_only_load", !(x_en && y_en) || (!x_sel && !y_sel && !output_en), 1);
            chk("oe_only_equal", !output_en || (!x_ne_y && !x_en && !y_en), 1);
            if (x_en ^ y_en) sub_cnt++;
            if (output_en) oe_cnt++;
            if (done) begin
                done_cnt++;
                chk("done_busy", busy, 1);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    if (!e.to) chk("result", rr, e.res);
                    chk("latency", cyc - start_cyc + 1, e.lat);
                    chk("subtractions", sub_cnt, e.subs);
                    chk("output_en_count", oe_cnt, e.to ? 0 : 1);
                    chk("timeout_flag", timeout_o, e.to);
                end
            end else begin
                chk("timeout_without_done", timeout_o, 0);
            end
        end
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a_in = a;
        b_in = b;
        sb_q.push_back(ref_op(a, b));
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_ops(input int unsigned target, input int unsigned budget);
        int unsigned k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("wait_done_bound", done_cnt >= target, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {x_sel, x_en, y_sel, y_en, output_en, busy, done, timeout_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_not_busy", busy, 0);

        // Two subtractions: X-sub then Y-sub, result 4, latency 5
        start_op(8'd12, 8'd8);
        wait_ops(1, 50);

        // Equal operands: no subtractions, latency 3
        start_op(8'd7, 8'd7);
        wait_ops(2, 50);

        // go pulsed while busy must be ignored
        start_op(8'd21, 8'd6);
        @(negedge clk);
        chk("busy_during_compute", busy, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_ops(3, 50);
        repeat (10) @(negedge clk);
        chk("single_done_after_busy_go", done_cnt, 3);

        // Back-to-back with go held high
        @(negedge clk);
        a_in = 8'd9;
        b_in = 8'd6;
        sb_q.push_back(ref_op(8'd9, 8'd6));
        sb_q.push_back(ref_op(8'd5, 8'd15));
        go = 1'b1;
        wait_ops(4, 50);
        @(negedge clk);
        a_in = 8'd5;
        b_in = 8'd15;
        @(negedge clk);
        go = 1'b0;
        wait_ops(5, 50);
        repeat (8) @(negedge clk);
        chk("b2b_done_count", done_cnt, 5);

        // Reset mid-COMPUTE: immediate IDLE, no resumption
        @(negedge clk);
        a_in = 8'd100;
        b_in = 8'd3;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        chk_all_zero("reset_held");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_resume_busy", busy, 0);
        chk("no_done_after_reset", done_cnt, 5);

        // Fresh operation after reset
        start_op(8'd9, 8'd6);
        wait_ops(6, 50);

`ifdef GCD_CTRL_TIMEOUT_EN
        // Zero operand: runs out of iterations
        start_op(8'd0, 8'd5);
        wait_ops(7, 60);
        @(negedge clk);
        chk("timeout_cleared", timeout_o, 0);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 SHALL provide parameter MAX_ITER, default 65535; the maximum number of subtraction cycles allowed per operation. It is used only when GCD_CTRL_TIMEOUT_EN is defined.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL provide port go, input, 1 bit: start request, sampled only in IDLE.
REQ-005 SHALL provide port x_lt_y, input, 1 bit: datapath comparator flag, X register < Y register.
REQ-006 SHALL provide port x_ne_y, input, 1 bit: datapath comparator flag, X register != Y register.
REQ-007 SHALL provide port x_sel, output, 1 bit: X mux select; 0 = external operand, 1 = subtractor result (X-Y).
REQ-008 SHALL provide port x_en, output, 1 bit: X register load enable.
REQ-009 SHALL provide port y_sel, output, 1 bit: Y mux select; 0 = external operand, 1 = subtractor result (Y-X).
REQ-010 SHALL provide port y_en, output, 1 bit: Y register load enable.
REQ-011 SHALL provide port output_en, output, 1 bit: result register load enable.
REQ-012 SHALL provide port busy, output, 1 bit: high whenever state != IDLE.
REQ-013 SHALL provide port done, output, 1 bit: one-cycle pulse; the datapath result register is valid in this cycle.
REQ-014 SHALL provide port timeout, output, 1 bit, only when GCD_CTRL_TIMEOUT_EN is defined.

Function
REQ-015 SHALL implement the states IDLE, LOAD, COMPUTE and DONE, held in a state register.
REQ-016 SHALL move from IDLE to LOAD on a rising clock edge with go=1; otherwise it remains in IDLE.
REQ-017 SHALL, in LOAD, drive x_en=1, y_en=1, x_sel=0, y_sel=0, then go to COMPUTE unconditionally.
REQ-018 SHALL, in COMPUTE with x_ne_y=1 and x_lt_y=1, drive y_en=1, y_sel=1, x_en=0 and remain in COMPUTE.
REQ-019 SHALL, in COMPUTE with x_ne_y=1 and x_lt_y=0, drive x_en=1, x_sel=1, y_en=0 and remain in COMPUTE.
REQ-020 SHALL, in COMPUTE with x_ne_y=0, drive output_en=1 with x_en=y_en=0, then go to DONE.
REQ-021 SHALL, in DONE, drive done=1 with all enables 0, then go to IDLE unconditionally.
REQ-022 SHALL decode the enables and selects combinationally from the current state and the flags; the selects SHALL be 0 whenever their enable is 0.
REQ-023 SHALL produce latency from the go-sampling edge to done equal to n+3 cycles, where n is the number of subtraction cycles.
REQ-024 SHALL ignore go while busy=1; a held go after DONE SHALL start a new operation from the following IDLE cycle.
REQ-025 SHALL never assert x_en and y_en together, except in LOAD.
REQ-026 SHALL never assert output_en outside the equal-flags COMPUTE cycle.

Reset
REQ-027 SHALL, on rst=1, enter IDLE immediately without waiting for a clock edge, including mid-operation.
REQ-028 SHALL hold every output at 0 during reset: x_sel, x_en, y_sel, y_en, output_en, busy, done, and timeout where present.
REQ-029 SHALL clear the iteration counter to 0 on reset, where the counter is present.
REQ-030 SHALL, after rst deasserts, wait for a new go before starting any operation; no operation resumes.

Configuration
REQ-031 SHALL, with GCD_CTRL_TIMEOUT_EN defined, include a counter of COMPUTE subtraction cycles, cleared in LOAD.
REQ-032 SHALL, with GCD_CTRL_TIMEOUT_EN defined, go to DONE when the count reaches MAX_ITER while x_ne_y=1, without asserting output_en.
REQ-033 SHALL, with GCD_CTRL_TIMEOUT_EN defined, assert timeout=1 only in the DONE cycle coincident with done, in the timeout case.
REQ-034 SHALL, without GCD_CTRL_TIMEOUT_EN, omit the timeout port and the counter; a zero operand then never terminates, and users SHALL NOT apply one.

Verification
REQ-035 SHALL cover reset: assert rst mid-COMPUTE -> same-cycle IDLE, all outputs 0, no done after release until a new go.
REQ-036 SHALL cover a two-subtraction case: go with x=12, y=8 -> X-sub (X=4), then Y-sub (Y=4), output_en, done 5 cycles after go edge, result 4.
REQ-037 SHALL cover equal operands: go with x=7, y=7 -> no subtractions, output_en in first COMPUTE cycle, done at cycle 3, result 7.
REQ-038 SHALL cover go while busy: pulse go during COMPUTE of x=21, y=6 -> ignored, single done, result 3.
REQ-039 SHALL cover back-to-back operations: hold go high across two operations (x=9,y=6 then x=5,y=15) -> two done pulses, results 3 then 5.
REQ-040 SHALL cover timeout: with GCD_CTRL_TIMEOUT_EN defined and MAX_ITER=8, go with x=0, y=5 -> 8 Y-sub cycles, done=1 and timeout=1, output_en never asserted.
